hd63701_sci_rx: RTL and testbench

HD63701_SCI_RX -- requirements
Module: hd63701_sci_rx

---
 rtl/hd63701_sci_rx.sv | 180 ++++++++++++++++++
 tb/tb_hd63701_sci_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hd63701_sci_rx.sv
// HD63701-style SCI receiver: 16x oversampled 8N1 deserializer with RDRF/ORFE status and read-sequence flag clearing.
// Define SCI_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of the samples at sub-bit counts 7, 8 and 9.
module hd63701_sci_rx #(
    parameter int CLKDIV = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RE,
    input  logic       RIE,
    input  logic       RXD,
    input  logic       RD_STAT,
    input  logic       RD_DATA,
    output logic [7:0] RDR,
    output logic       RDRF,
    output logic       ORFE,
    output logic       IRQ
);

    localparam int PW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

`ifdef SCI_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE = 4'd9;
`else
    localparam logic [3:0] DECIDE = 4'd8;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic            rxdMeta;
    logic            rxdSync;
    logic [PW-1:0]   prescaler;
    logic [3:0]      subCnt;
    logic [2:0]      bitCnt;
    logic [7:0]      shiftReg;
    logic            armed;
    logic            waitHigh;

    logic            tick;
    logic            decideNow;
    logic            bitVal;
    logic            statusHasFlag;
    logic            clearNow;
    logic            rdrfEff;
    logic            orfeEff;
    logic            stopEvent;

`ifdef SCI_RX_MAJORITY_EN
    logic            samp7;
    logic            samp8;
    assign bitVal = (samp7 & samp8) | (samp7 & rxdSync) | (samp8 & rxdSync);
`else
    assign bitVal = rxdSync;
`endif

    always_comb begin
        tick          = (prescaler == PW'(CLKDIV - 1));
        decideNow     = tick && (subCnt == DECIDE);
        statusHasFlag = RDRF | ORFE;
        // A same-cycle status+data read behaves as status-then-data.
        clearNow      = RD_DATA && (armed || (RD_STAT && statusHasFlag));
        rdrfEff       = RDRF && !clearNow;
        orfeEff       = ORFE && !clearNow;
        stopEvent     = RE && (state == STOP) && decideNow;
    end

    assign IRQ = (RDRF | ORFE) & RIE;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            rxdMeta   <= 1'b1;
            rxdSync   <= 1'b1;
            prescaler <= '0;
            subCnt    <= 4'd0;
            bitCnt    <= 3'd0;
            shiftReg  <= 8'h00;
            RDR       <= 8'h00;
            RDRF      <= 1'b0;
            ORFE      <= 1'b0;
            armed     <= 1'b0;
            waitHigh  <= 1'b0;
`ifdef SCI_RX_MAJORITY_EN
            samp7     <= 1'b1;
            samp8     <= 1'b1;
`endif
        end else begin
            rxdMeta <= RXD;
            rxdSync <= rxdMeta;

            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            // Clearing read is applied before the completing frame is judged.
            RDRF <= rdrfEff;
            ORFE <= orfeEff;
            if (clearNow) begin
                armed <= 1'b0;
            end else if (RD_STAT && statusHasFlag) begin
                armed <= 1'b1;
            end

            if (stopEvent) begin
                if (!bitVal || rdrfEff) begin
                    ORFE <= 1'b1;
                end else begin
                    RDR  <= shiftReg;
                    RDRF <= 1'b1;
                end
            end

`ifdef SCI_RX_MAJORITY_EN
            if (tick && (subCnt == 4'd7)) begin
                samp7 <= rxdSync;
            end
            if (tick && (subCnt == 4'd8)) begin
                samp8 <= rxdSync;
            end
`endif

            if (!RE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rxdSync) begin
                            waitHigh <= 1'b0;
                        end
                        if (tick && !rxdSync && !waitHigh) begin
                            state  <= START;
                            subCnt <= 4'd0;
                        end
                    end
                    START: begin
                        if (tick) begin
                            subCnt <= subCnt + 4'd1;
                            if (subCnt == DECIDE) begin
                                if (bitVal) begin
                                    state <= IDLE;
                                end else begin
                                    state  <= DATA;
                                    bitCnt <= 3'd0;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            subCnt <= subCnt + 4'd1;
                            if (subCnt == DECIDE) begin
                                shiftReg <= {bitVal, shiftReg[7:1]};
                                bitCnt   <= bitCnt + 3'd1;
                                if (bitCnt == 3'd7) begin
                                    state <= STOP;
                                end
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            subCnt <= subCnt + 4'd1;
                            if (subCnt == DECIDE) begin
                                state <= IDLE;
                                // A low stop bit leaves the line low; wait for it to go high before re-arming.
                                if (!bitVal) begin
                                    waitHigh <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hd63701_sci_rx.sv
// Self-checking bench for hd63701_sci_rx (CLKDIV=1): directed frames plus randomized frames and read strobes,
// checked every cycle against a frame-level model of the status/data registers.
module tb_hd63701_sci_rx;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RE = 1'b0;
    logic       RIE = 1'b0;
    logic       RXD = 1'b1;
    logic       RD_STAT = 1'b0;
    logic       RD_DATA = 1'b0;
    logic [7:0] RDR;
    logic       RDRF;
    logic       ORFE;
    logic       IRQ;

    // Posedges from the first low line sample to the posedge that commits the frame:
    // 2 sync + 1 start detect + start bit centre (count 8) + 9 more bit times.
`ifdef SCI_RX_MAJORITY_EN
    localparam int FRAME_LAT = 2 + 1 + 8 + 16 * 9 + 1;
`else
    localparam int FRAME_LAT = 2 + 1 + 8 + 16 * 9;
`endif

    typedef struct {
        int         due;
        logic [7:0] data;
        logic       stop;
    } frame_t;

    frame_t     frameQ[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mRdr = 8'h00;
    logic       mRdrf = 1'b0;
    logic       mOrfe = 1'b0;
    logic       mArmed = 1'b0;

    hd63701_sci_rx #(.CLKDIV(1)) dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .RE      (RE),
        .RIE     (RIE),
        .RXD     (RXD),
        .RD_STAT (RD_STAT),
        .RD_DATA (RD_DATA),
        .RDR     (RDR),
        .RDRF    (RDRF),
        .ORFE    (ORFE),
        .IRQ     (IRQ)
    );

    always #5 CLK = ~CLK;

    // Model step and per-cycle comparison, 1 time unit after each rising edge.
    initial begin
        forever begin
            logic       hadFlag;
            logic       clr;
            logic [11:0] expV;
            logic [11:0] actV;
            frame_t     fr;
            @(posedge CLK);
            cyc++;
            #1;
            if (!RSTn) begin
                mRdr = 8'h00; mRdrf = 1'b0; mOrfe = 1'b0; mArmed = 1'b0;
                frameQ.delete();
            end else begin
                hadFlag = mRdrf | mOrfe;
                clr = RD_DATA && (mArmed || (RD_STAT && hadFlag));
                if (clr) begin
                    mRdrf = 1'b0;
                    mOrfe = 1'b0;
                end
                if (frameQ.size() > 0 && frameQ[0].due == cyc) begin
                    fr = frameQ.pop_front();
                    if (!fr.stop || mRdrf) begin
                        mOrfe = 1'b1;
                    end else begin
                        mRdr  = fr.data;
                        mRdrf = 1'b1;
                    end
                end
                if (clr) mArmed = 1'b0;
                else if (RD_STAT && hadFlag) mArmed = 1'b1;
            end
            expV = {1'b0, mRdr, mRdrf, mOrfe, (mRdrf | mOrfe) & RIE};
            actV = {1'b0, RDR, RDRF, ORFE, IRQ};
            checks++;
            if (actV !== expV) begin
                errors++;
                $display("FAIL outputs cyc=%0d got RDR=%h RDRF=%b ORFE=%b IRQ=%b want RDR=%h RDRF=%b ORFE=%b IRQ=%b",
                         cyc, RDR, RDRF, ORFE, IRQ, mRdr, mRdrf, mOrfe, (mRdrf | mOrfe) & RIE);
            end
        end
    end

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end else begin
            $display("check %s = %h", name, act);
        end
    endtask

    task automatic idle(input int n);
        RXD = 1'b1; RD_STAT = 1'b0; RD_DATA = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic readStatus();
        RD_STAT = 1'b1;
        @(negedge CLK);
        RD_STAT = 1'b0;
    endtask

    task automatic readData();
        RD_DATA = 1'b1;
        @(negedge CLK);
        RD_DATA = 1'b0;
    endtask

    // abortMode: 0 normal, 1 drop RE mid-frame, 2 pulse reset mid-frame.
    task automatic sendFrame(input logic [7:0] data, input logic stop, input int glitchBit,
                             input bit rnd, input bit clrAtEnd, input int abortMode);
        int     f;
        logic   b;
        frame_t fr;
        f = cyc + 1;
        if (abortMode == 0) begin
            fr.due = f + FRAME_LAT; fr.data = data; fr.stop = stop;
            frameQ.push_back(fr);
        end
        $display("frame data=%h stop=%b glitch=%0d rnd=%0d clr=%0d abort=%0d start=%0d",
                 data, stop, glitchBit, rnd, clrAtEnd, abortMode, f);
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 16; k++) begin
                if (abortMode == 2 && j * 16 + k == 40) begin
                    RSTn = 1'b0; RXD = 1'b1; RD_STAT = 1'b0; RD_DATA = 1'b0;
                    @(negedge CLK);
                    RSTn = 1'b1;
                    return;
                end
                if (abortMode == 1 && j * 16 + k == 40) RE = 1'b0;
                if (j == 0) b = 1'b0;
                else if (j == 9) b = stop;
                else b = data[j-1];
                if (j >= 1 && j <= 8 && (j - 1) == glitchBit && k == 9) b = ~b;
                RXD = b;
                RD_STAT = rnd && ($urandom_range(0, 11) == 0);
                RD_DATA = (rnd && ($urandom_range(0, 11) == 0)) || (clrAtEnd && (cyc + 1 == f + FRAME_LAT));
                @(negedge CLK);
            end
        end
        RXD = 1'b1; RD_STAT = 1'b0; RD_DATA = 1'b0;
        if (abortMode == 1) RE = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        checkLit("reset RDR", {24'd0, RDR}, 32'h00);
        checkLit("reset flags", {29'd0, RDRF, ORFE, IRQ}, 32'h0);
        RSTn = 1'b1; RE = 1'b1; RIE = 1'b1;
        idle(20);

        sendFrame(8'hA5, 1'b1, -1, 1'b0, 1'b0, 0); idle(10);
        checkLit("A5 RDR", {24'd0, RDR}, 32'hA5);
        checkLit("A5 flags", {29'd0, RDRF, ORFE, IRQ}, 32'b101);
        checkLit("model A5", {23'd0, mRdr, mRdrf}, {23'd0, 8'hA5, 1'b1});

        sendFrame(8'h3C, 1'b1, -1, 1'b0, 1'b0, 0); idle(10);
        checkLit("overrun RDR", {24'd0, RDR}, 32'hA5);
        checkLit("overrun flags", {29'd0, RDRF, ORFE, IRQ}, 32'b111);
        readStatus(); readData(); idle(2);
        checkLit("cleared flags", {29'd0, RDRF, ORFE, IRQ}, 32'b000);

        sendFrame(8'h55, 1'b0, -1, 1'b0, 1'b0, 0); idle(10);
        checkLit("framing RDR", {24'd0, RDR}, 32'hA5);
        checkLit("framing flags", {30'd0, RDRF, ORFE}, 32'b01);
        sendFrame(8'h81, 1'b1, -1, 1'b0, 1'b0, 0); idle(10);
        checkLit("81 RDR", {24'd0, RDR}, 32'h81);
        checkLit("81 RDRF", {31'd0, RDRF}, 32'h1);

        RXD = 1'b0; repeat (4) @(negedge CLK);
        idle(30);
        checkLit("false start RDR", {24'd0, RDR}, 32'h81);
        checkLit("false start flags", {30'd0, RDRF, ORFE}, 32'b11);
        readData(); idle(2);
        checkLit("unarmed read RDRF", {31'd0, RDRF}, 32'h1);
        readStatus(); readData(); idle(2);

        sendFrame(8'h11, 1'b1, -1, 1'b0, 1'b0, 0); idle(6);
        readStatus(); idle(4);
        sendFrame(8'h22, 1'b1, -1, 1'b0, 1'b1, 0); idle(10);
        checkLit("clear+frame RDR", {24'd0, RDR}, 32'h22);
        checkLit("clear+frame flags", {30'd0, RDRF, ORFE}, 32'b10);

        sendFrame(8'h99, 1'b1, -1, 1'b0, 1'b0, 1); idle(20);
        checkLit("RE abort RDR", {24'd0, RDR}, 32'h22);
        checkLit("RE abort flags", {30'd0, RDRF, ORFE}, 32'b10);

        sendFrame(8'hE7, 1'b1, -1, 1'b0, 1'b0, 2); @(negedge CLK);
        checkLit("mid reset RDR", {24'd0, RDR}, 32'h00);
        checkLit("mid reset flags", {29'd0, RDRF, ORFE, IRQ}, 32'b000);
        idle(20);
        sendFrame(8'h0F, 1'b1, -1, 1'b0, 1'b0, 0); idle(10);
        checkLit("0F RDR", {24'd0, RDR}, 32'h0F);
        checkLit("0F RDRF", {31'd0, RDRF}, 32'h1);
        readStatus(); readData(); idle(4);

`ifdef SCI_RX_MAJORITY_EN
        sendFrame(8'hC3, 1'b1, 2, 1'b0, 1'b0, 0); idle(10);
        checkLit("glitch RDR", {24'd0, RDR}, 32'hC3);
        readStatus(); readData(); idle(4);
`endif

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom);
            s = ($urandom_range(0, 5) != 0);
            RIE = 1'($urandom_range(0, 1));
            sendFrame(d, s, -1, 1'b1, 1'b0, 0);
            idle($urandom_range(4, 20));
        end
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
